// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplication sequencer.
// Holds the controller state encoding and the default operand widths
// used by binary_multiplication_sequencer and mult_step_adder.
package mult_pkg;

  // Default multiplier width (also the number of add/shift steps)
  localparam int DEF_A_W = 3;
  // Default multiplicand width (also the adder width)
  localparam int DEF_B_W = 4;
  // Default product width
  localparam int DEF_P_W = DEF_A_W + DEF_B_W;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_step_adder.sv
// One combinational shift-and-add step.
// The accumulator holds {hi, low}, where hi is the B_W+1 bit partial sum
// (including its carry) and low holds the multiplier bits not yet consumed.
// The LSB of acc picks whether the multiplicand is added into hi, then the
// whole accumulator shifts right by one.
// Ports:
//   acc      in   P_W+1  current accumulator
//   b_reg    in   B_W    latched multiplicand
//   acc_next out  P_W+1  accumulator after the add and the shift
module mult_step_adder
  import mult_pkg::*;
#(
  parameter int  A_W = DEF_A_W,
  parameter int  B_W = DEF_B_W,
  localparam int P_W = A_W + B_W
) (
  input  logic [P_W:0]   acc,
  input  logic [B_W-1:0] b_reg,
  output logic [P_W:0]   acc_next
);

  logic [B_W:0] hi;

  // Conditional add into the upper half, then shift the full accumulator
  // right; the vacated MSB is always zero because hi never exceeds
  // 2^(B_W+1)-1 and its top bit is cleared by every shift.
  always_comb begin
    hi = acc[P_W:A_W];
    if (acc[0]) begin
      hi = acc[P_W:A_W] + {1'b0, b_reg};
    end
    acc_next = {1'b0, hi, acc[A_W-1:1]};
  end

endmodule

// File: rtl/binary_multiplication_sequencer.sv
// Sequential unsigned A_W x B_W multiplier built from a single B_W-bit
// adder that is reused over A_W clock cycles.
// Handshake: start is taken only while ready; busy marks the add/shift
// cycles; done pulses for one cycle when p is freshly loaded. p then holds
// the product until the next operation finishes (or reset).
// Ports:
//   clk    in   1    rising-edge clock
//   rst    in   1    synchronous active-high reset
//   start  in   1    request, honoured only while ready=1
//   a      in   A_W  multiplier, captured on the accepting edge
//   b      in   B_W  multiplicand, captured on the accepting edge
//   ready  out  1    controller idle
//   busy   out  1    add/shift in progress
//   done   out  1    one-cycle completion pulse
//   p      out  P_W  product register
module binary_multiplication_sequencer
  import mult_pkg::*;
#(
  parameter int  A_W   = DEF_A_W,
  parameter int  B_W   = DEF_B_W,
  localparam int P_W   = A_W + B_W,
  localparam int CNT_W = $clog2(A_W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] p
);

  state_t           state_q, state_d;
  logic [P_W:0]     acc_q, acc_d;
  logic [B_W-1:0]   b_reg_q, b_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [P_W:0]     acc_next;

  mult_step_adder #(
    .A_W(A_W),
    .B_W(B_W)
  ) u_step (
    .acc      (acc_q),
    .b_reg    (b_reg_q),
    .acc_next (acc_next)
  );

  // Next-state and datapath control. Every operation runs all A_W steps,
  // so a zero operand still takes the full latency. p is only written on
  // the edge that enters DONE, which keeps the previous product visible
  // throughout the following operation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_reg_d = b_reg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          b_reg_d = b;
          acc_d   = {{(B_W + 1){1'b0}}, a};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(A_W - 1)) begin
          p_d     = acc_next[P_W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  // and clears the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_reg_q <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_reg_q <= b_reg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == CALC);
  assign done  = (state_q == DONE);
  assign p     = p_q;

endmodule

// File: tb/tb_binary_multiplication_sequencer.sv
// Self-checking bench for binary_multiplication_sequencer.
// The reference model is plain arithmetic: each finished operation must
// report a*b, arrive A_W edges after the accepting edge, and leave p
// untouched at every other time.
module tb_binary_multiplication_sequencer;

  localparam int A_W = 3;
  localparam int B_W = 4;
  localparam int P_W = A_W + B_W;

  logic           clk;
  logic           rst;
  logic           start;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [P_W-1:0] p;

  int             compared;
  int             mismatched;
  logic [P_W-1:0] model_p;

  binary_multiplication_sequencer #(
    .A_W(A_W),
    .B_W(B_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it; inputs are driven
  // and outputs sampled at this point, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One full operation started at the first ready cycle. Optionally
  // scrambles a and b while the operation runs, which must not matter.
  task automatic applyStimulus(input logic [A_W-1:0] op_a,
                               input logic [B_W-1:0] op_b,
                               input bit scramble);
    int edges;
    edges = 0;
    while (ready !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    checkOutput("ready_before_start", 32'(ready), 32'd1);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("accept_ready_low", 32'(ready), 32'd0);
    checkOutput("accept_busy_high", 32'(busy), 32'd1);
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      checkOutput("p_hold_during_calc", 32'(p), 32'(model_p));
      if (scramble) begin
        a = A_W'($urandom);
        b = B_W'($urandom);
      end
      tick();
      edges++;
    end
    // A_W edges after the accepting edge, i.e. A_W+1 edges counting it
    checkOutput("latency_edges", 32'(edges), 32'(A_W));
    model_p = P_W'(op_a) * P_W'(op_b);
    checkOutput("product", 32'(p), 32'(model_p));
    tick();
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("ready_after_done", 32'(ready), 32'd1);
    checkOutput("p_held_after_done", 32'(p), 32'(model_p));
  endtask

  initial begin
    int edges;
    int done_seen;
    compared   = 0;
    mismatched = 0;
    model_p    = '0;
    rst        = 1'b1;
    start      = 1'b0;
    a          = '0;
    b          = '0;

    // Reset for two cycles
    tick();
    tick();
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_p", 32'(p), 32'd0);
    rst = 1'b0;

    // Single operation 5 x 11
    applyStimulus(3'd5, 4'd11, 1'b0);

    // Exhaustive sweep, back to back
    for (int i = 0; i < (1 << A_W); i++) begin
      for (int j = 0; j < (1 << B_W); j++) begin
        applyStimulus(A_W'(i), B_W'(j), 1'b0);
      end
    end

    // Random operands with operand noise during CALC
    for (int k = 0; k < 40; k++) begin
      applyStimulus(A_W'($urandom), B_W'($urandom), 1'b1);
    end

    // Start held through CALC and DONE with new operands
    a     = 3'd3;
    b     = 4'd4;
    start = 1'b1;
    tick();
    a     = 3'd7;
    b     = 4'd15;
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    checkOutput("held_start_first_product", 32'(p), 32'd12);
    tick();
    checkOutput("held_start_ignored_in_done", 32'(ready), 32'd1);
    tick();
    checkOutput("held_start_accepted_in_idle", 32'(busy), 32'd1);
    start = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    checkOutput("held_start_second_product", 32'(p), 32'd105);
    model_p   = 7'd105;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    checkOutput("no_extra_done", 32'(done_seen), 32'd0);

    // Reset during the second CALC cycle of 6 x 9
    a     = 3'd6;
    b     = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("midop_busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_p = '0;
    checkOutput("midop_reset_ready", 32'(ready), 32'd1);
    checkOutput("midop_reset_busy", 32'(busy), 32'd0);
    checkOutput("midop_reset_done", 32'(done), 32'd0);
    checkOutput("midop_reset_p", 32'(p), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    checkOutput("midop_no_done", 32'(done_seen), 32'd0);

    // Product hold, then start and reset on the same edge
    applyStimulus(3'd5, 4'd11, 1'b0);
    a     = 3'd7;
    b     = 4'd15;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    model_p = '0;
    checkOutput("start_with_reset_p", 32'(p), 32'd0);
    checkOutput("start_with_reset_not_busy", 32'(busy), 32'd0);
    checkOutput("start_with_reset_ready", 32'(ready), 32'd1);
    applyStimulus(3'd2, 4'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
